// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types, forwarding encodings and the scoreboard match helper.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } sb_entry_t;

    function automatic logic sb_match(sb_entry_t e, logic [4:0] rs, logic uses);
        return e.valid & e.reg_write & (e.rd != REG_ZERO) & (e.rd == rs) & uses;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB destination tracking and source-register match flags.
// The WB entry only ever feeds the register file, so no output depends on it.
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       issue,
    input  sb_entry_t  id_e,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    output sb_entry_t  ex_e,
    output sb_entry_t  mem_e,
    output logic       ex_m1,
    output logic       ex_m2,
    output logic       mem_m1,
    output logic       mem_m2
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_e  <= '0;
            mem_e <= '0;
        end else if (advance) begin
            mem_e <= ex_e;
            ex_e  <= issue ? id_e : '0;
        end
    end

    assign ex_m1  = sb_match(ex_e, rs1, uses_rs1);
    assign ex_m2  = sb_match(ex_e, rs2, uses_rs2);
    assign mem_m1 = sb_match(mem_e, rs1, uses_rs1);
    assign mem_m2 = sb_match(mem_e, rs2, uses_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/freeze generation, registered EXE forwarding selects and stall counter.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [4:0]             id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_is_load,
    input  logic                   id_is_branch,
    input  logic                   id_branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   flush_id,
    output logic                   bubble_ex,
    output logic                   freeze_all,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_count
);

    sb_entry_t ex_e, mem_e, id_e;
    logic      ex_m1, ex_m2, mem_m1, mem_m2;
    logic      load_use, br_hz, hz, issue;
    logic [1:0] sel_a, sel_b;

    assign id_e = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};

    hazard_scoreboard u_sb (
        .clk      (clk),
        .reset    (reset),
        .advance  (~freeze_all),
        .issue    (issue),
        .id_e     (id_e),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .uses_rs1 (id_uses_rs1),
        .uses_rs2 (id_uses_rs2),
        .ex_e     (ex_e),
        .mem_e    (mem_e),
        .ex_m1    (ex_m1),
        .ex_m2    (ex_m2),
        .mem_m1   (mem_m1),
        .mem_m2   (mem_m2)
    );

    // Decode-stage compares cannot take forwarded EXE data, so any ex producer stalls a branch.
    assign freeze_all = mem_req & ~mem_ready;
    assign load_use   = ex_e.is_load & (ex_m1 | ex_m2);
    assign br_hz      = id_is_branch & (ex_m1 | ex_m2 | (mem_e.is_load & (mem_m1 | mem_m2)));
    assign hz         = ~freeze_all & (load_use | br_hz);
    assign issue      = id_valid & ~hz;

    assign stall_if  = hz | freeze_all;
    assign stall_id  = hz | freeze_all;
    assign bubble_ex = hz;
    assign flush_id  = id_valid & id_is_branch & id_branch_taken & ~hz & ~freeze_all;

    assign sel_a = ex_m1 ? FWD_MEM : mem_m1 ? FWD_WB : FWD_REG;
    assign sel_b = ex_m2 ? FWD_MEM : mem_m2 ? FWD_WB : FWD_REG;

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a       <= FWD_REG;
            fwd_b       <= FWD_REG;
            stall_count <= '0;
        end else begin
            if (!freeze_all) begin
                fwd_a <= issue ? sel_a : FWD_REG;
                fwd_b <= issue ? sel_b : FWD_REG;
            end
            if (stall_if && !(&stall_count))
                stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load;
    logic         id_is_branch, id_branch_taken, mem_req, mem_ready;
    logic [4:0]   id_rs1, id_rs2, id_rd;
    logic         stall_if, stall_id, flush_id, bubble_ex, freeze_all;
    logic [1:0]   fwd_a, fwd_b;
    logic [W-1:0] stall_count;

    int vectors = 0;
    int miscompares = 0;

    hazard_ctrl #(.STALL_CNT_W(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_is_load      (id_is_load),
        .id_is_branch    (id_is_branch),
        .id_branch_taken (id_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush_id        (flush_id),
        .bubble_ex       (bubble_ex),
        .freeze_all      (freeze_all),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic ld, input logic br, input logic tk);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_is_load = ld; id_is_branch = br; id_branch_taken = tk;
        #1;
    endtask

    task automatic clr_id();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1; mem_req = 0; mem_ready = 0;
        clr_id();
        tick();
        tick();
        reset = 0;
    endtask

    task automatic check_stall(input string tag, input int s);
        check({tag, ".stall_if"}, stall_if, s);
        check({tag, ".stall_id"}, stall_id, s);
        check({tag, ".bubble_ex"}, bubble_ex, s);
    endtask

    initial begin
        do_reset();
        check("rst.fwd_a", fwd_a, 0);
        check("rst.fwd_b", fwd_b, 0);
        check("rst.cnt", stall_count, 0);
        check("rst.stall_if", stall_if, 0);
        check("rst.flush", flush_id, 0);
        check("rst.freeze", freeze_all, 0);
        check("rst.bubble", bubble_ex, 0);

        // load-use: lw x5 ; add x6,x5,x1
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        check_stall("lu.lw", 0);
        tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        check_stall("lu.hz", 1);
        tick();
        check_stall("lu.go", 0);
        tick();
        clr_id();
        check("lu.fwd_a", fwd_a, 2);
        check("lu.fwd_b", fwd_b, 0);
        check("lu.cnt", stall_count, 1);

        // ALU chain: add x3,x1,x2 ; sub x4,x3,x3 ; or x7,x3,x4
        do_reset();
        set_id(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0, 0, 0);
        check_stall("alu.sub", 0);
        tick();
        check("alu.sub.fwd_a", fwd_a, 1);
        check("alu.sub.fwd_b", fwd_b, 1);
        set_id(1, 3, 4, 1, 1, 7, 1, 0, 0, 0);
        check_stall("alu.or", 0);
        tick();
        check("alu.or.fwd_a", fwd_a, 2);
        check("alu.or.fwd_b", fwd_b, 1);
        clr_id();
        tick();
        check("alu.idle.fwd_a", fwd_a, 0);
        check("alu.cnt", stall_count, 0);

        // branch after load: lw x2 ; beq x2,x0 taken
        do_reset();
        set_id(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
        tick();
        set_id(1, 2, 0, 1, 1, 0, 0, 0, 1, 1);
        check_stall("bl.1", 1);
        check("bl.1.flush", flush_id, 0);
        tick();
        check_stall("bl.2", 1);
        check("bl.2.flush", flush_id, 0);
        tick();
        check_stall("bl.3", 0);
        check("bl.3.flush", flush_id, 1);
        check("bl.cnt", stall_count, 2);
        tick();
        clr_id();
        check("bl.4.flush", flush_id, 0);

        // branch after ALU: add x2 ; beq x2,x0 taken -> one stall
        do_reset();
        set_id(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        tick();
        set_id(1, 2, 0, 1, 1, 0, 0, 0, 1, 1);
        check_stall("ba.1", 1);
        tick();
        check_stall("ba.2", 0);
        check("ba.2.flush", flush_id, 1);
        check("ba.cnt", stall_count, 1);

        // freeze with taken beq in ID; add x1 sits in ex and must stay there
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        tick();
        set_id(1, 3, 4, 1, 1, 0, 0, 0, 1, 1);
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fz.freeze", freeze_all, 1);
            check("fz.flush", flush_id, 0);
            check("fz.stall_if", stall_if, 1);
            check("fz.bubble", bubble_ex, 0);
            tick();
        end
        mem_ready = 1;
        #1;
        check("fz.rel.freeze", freeze_all, 0);
        check("fz.rel.flush", flush_id, 1);
        check("fz.rel.stall_if", stall_if, 0);
        check("fz.cnt", stall_count, 3);
        tick();
        mem_req = 0; mem_ready = 0;
        set_id(1, 1, 1, 1, 1, 6, 1, 0, 0, 0);
        check_stall("fz.held", 0);
        tick();
        check("fz.held.fwd_a", fwd_a, 2);
        check("fz.held.fwd_b", fwd_b, 2);

        // rd=0: addi x0 ; add x1,x0,x0 ; lw x0 ; add x2,x0,x0
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 1, 1, 1, 1, 0, 0, 0);
        check_stall("r0.add", 0);
        tick();
        check("r0.fwd_a", fwd_a, 0);
        check("r0.fwd_b", fwd_b, 0);
        set_id(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        set_id(1, 0, 0, 1, 1, 2, 1, 0, 1, 0);
        check_stall("r0.lw", 0);
        tick();
        clr_id();

        // reset during a freeze that is also hiding a load-use
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick();
        set_id(1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
        mem_req = 1; mem_ready = 0;
        #1;
        check("rf.freeze", freeze_all, 1);
        check("rf.bubble", bubble_ex, 0);
        tick();
        reset = 1;
        tick();
        reset = 0; mem_req = 0;
        #1;
        check_stall("rf.after", 0);
        check("rf.freeze0", freeze_all, 0);
        check("rf.flush0", flush_id, 0);
        check("rf.fwd_a", fwd_a, 0);
        check("rf.cnt", stall_count, 0);

        // saturation at 15 with a 4-bit counter
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 14; i++) tick();
        check("sat.14", stall_count, 14);
        for (int i = 0; i < 6; i++) tick();
        check("sat.15", stall_count, 15);
        mem_req = 0;
        tick();
        check("sat.hold", stall_count, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core (fetch, Decode, EXE, MEM, WB). It keeps its own scoreboard of the instructions in EX, MEM and WB and uses it to generate three kinds of control. First, PC/IF_ID hold, IF_ID flush and ID_EX bubble controls. Second, registered forwarding selects for EXE. Third, a global freeze while the data memory is busy. Branches resolve in Decode, so it also inserts the extra stalls that decode-stage compares need.

## Interface
- STALL_CNT_W, 16: width of the saturating stall-cycle counter.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- id_valid  in  1  ID holds a real instruction (0 = bubble).
- id_rs1, id_rs2  in  5  source register numbers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  the instruction actually reads that source.
- id_rd  in  5  destination register of the instruction in ID.
- id_reg_write  in  1  the instruction in ID writes id_rd.
- id_is_load  in  1  the instruction in ID is a load.
- id_is_branch  in  1  the instruction in ID is a branch (compare in Decode).
- id_branch_taken  in  1  Decode's Select_PC; only valid when no stall is asserted.
- mem_req  in  1  MEM stage has an access outstanding.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF_ID.
- flush_id  out  1  load a bubble into IF_ID.
- bubble_ex  out  1  load a bubble (RegWrite=0, Mem_Ctrl=0) into ID_EX.
- freeze_all  out  1  hold ID_EX, EX_MEM and MEM_WB.
- fwd_a, fwd_b  out  2  EXE operand select: 00 = register file, 01 = EX_MEM ALU result, 10 = WB write data.
- stall_count  out  STALL_CNT_W  saturating count of cycles with stall_if=1.

## Operation
- Scoreboard has three entries, ex, mem and wb. Each entry holds {valid, rd, reg_write, is_load}.
- Scoreboard advance (one clock edge, only when freeze_all=0):
  - wb takes mem.
  - mem takes ex.
  - ex takes the ID instruction if it issues; otherwise ex becomes invalid.
- The instruction in ID issues when id_valid=1 and no hazard stall is active.
- An entry matches a source register when it is valid, has reg_write=1, rd≠0, rd equals the source, and the ID instruction uses that source.
- Load-use hazard: ex is a load and matches rs1 or rs2.
- Branch hazard (only when id_is_branch=1), either of:
  - ex matches, whether or not it is a load;
  - mem is a load and matches.
- Hazard stall = load-use hazard OR branch hazard, evaluated only when freeze_all=0.
  - Drives stall_if=1, stall_id=1 and bubble_ex=1.
- Memory freeze: freeze_all = mem_req & ~mem_ready.
  - Also forces stall_if=1 and stall_id=1.
  - Forces bubble_ex=0 and flush_id=0, and holds the scoreboard.
- Branch flush: flush_id = id_valid & id_is_branch & id_branch_taken & ~hazard stall & ~freeze_all.
  - A stalled or frozen branch defers its flush until the cycle it actually resolves.
- Forwarding selects are computed at issue, for each source of the issuing instruction:
  - 01 if the current ex entry matches;
  - else 10 if the current mem entry matches;
  - else 00.
  - The select is registered so it is valid during the instruction's EX cycle.
  - If nothing issues, the select register loads 00.
  - The select register holds during freeze_all.
- stall_count increments on every cycle with stall_if=1 and saturates at all-ones.

## Timing
- Reset values:
  - All scoreboard entries invalid.
  - fwd_a = fwd_b = 00.
  - stall_count = 0.
  - Combinational outputs evaluate to 0 in the first cycle after reset (given mem_req=0).
- stall_if, stall_id, flush_id, bubble_ex and freeze_all are combinational, same cycle as their inputs. fwd_a/fwd_b and stall_count are registered.
- Stall lengths:
  - Load-use: exactly 1 cycle.
  - Branch after ALU producer: 1 cycle.
  - Branch after load producer: 2 cycles.
  - Freeze: lasts while mem_req & ~mem_ready; the pipeline resumes on the cycle after mem_ready=1.
- Simultaneous events:
  - freeze and hazard together: freeze wins, and the hazard is re-evaluated after release;
  - freeze and taken branch together: the flush is deferred;
  - both sources matching different stages: the ex match has priority.
- rd=0 never stalls and never forwards.
- Reset asserted mid-stall or mid-freeze clears everything on that edge; no stall survives reset.

## Structure
- Package pipe_ctrl_pkg holds:
  - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - struct sb_entry_t {valid, rd[4:0], reg_write, is_load};
  - REG_ZERO=5'd0.
- Sub-module hazard_scoreboard contains the three-entry shift register with advance and hold control, plus the match comparators.
- hazard_ctrl contains the stall, flush and freeze logic, the forwarding registers and the counter.

## Test plan
- Load-use: issue lw x5, then add x6,x5,x1 → one cycle with stall_if=stall_id=bubble_ex=1; add then enters EX with fwd_a=10; stall_count=1.
- ALU chain: add x3,.. / sub x4,x3,x3 / or x7,x3,x4 →
  - no stalls;
  - sub gets fwd_a=fwd_b=01;
  - or gets fwd_a=10 and fwd_b=01.
- Branch after load: lw x2 then beq x2,x0 with id_branch_taken=1 → 2 stall cycles, then flush_id=1 for one cycle; stall_count=2.
- Freeze: mem_req=1 and mem_ready=0 for 3 cycles while ID holds beq (taken, no hazard) → freeze_all=1 for 3 cycles, flush_id=0 throughout, scoreboard unchanged; flush_id=1 on the release cycle.
- rd=0: addi x0 then add x1,x0,x0 → no stall, fwd_a=fwd_b=00.
- Reset mid-freeze, plus saturation:
  - assert reset during a freeze → next cycle all outputs 0 and scoreboard empty;
  - hold stalls with STALL_CNT_W=4 → stall_count sticks at 15.
